// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared FSM encoding and default geometry for the bank scanner
package mem_pkg;

   localparam int DEF_SEL  = 2;
   localparam int DEF_WORD = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/mem_bank_regs.sv
// rtl/mem_bank_regs.sv - register bank with one write port and packed output
// Optional synchronous bank clear when MEM_BANK_CLEAR_EN is defined.
module mem_bank_regs
   import mem_pkg::*;
#(
   parameter int SEL  = DEF_SEL,
   parameter int WORD = DEF_WORD
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wr_en,
   input  logic [SEL-1:0]            wr_addr,
   input  logic [WORD-1:0]           wr_data,
`ifdef MEM_BANK_CLEAR_EN
   input  logic                      clear,
`endif
   output logic [(2**SEL)*WORD-1:0]  data_flat
);

   localparam int N = 2**SEL;

   logic [WORD-1:0] mem_q [N];
   logic [WORD-1:0] mem_d [N];

   always_comb begin
      mem_d = mem_q;
`ifdef MEM_BANK_CLEAR_EN
      // Clear takes priority over a coincident write.
      if (clear) begin
         for (int i = 0; i < N; i++) mem_d[i] = '0;
      end else if (wr_en) begin
         mem_d[wr_addr] = wr_data;
      end
`else
      if (wr_en) mem_d[wr_addr] = wr_data;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) mem_q[i] <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_flat
      assign data_flat[WORD*g +: WORD] = mem_q[g];
   end

endmodule

// File: rtl/mem_bank_scan.sv
// rtl/mem_bank_scan.sv - register bank plus handshaked index scanner for a downstream mux
// Define MEM_BANK_CLEAR_EN to add the Clear input that zeros the bank.
module mem_bank_scan
   import mem_pkg::*;
#(
   parameter int SEL  = DEF_SEL,
   parameter int WORD = DEF_WORD
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      WrEn,
   input  logic [SEL-1:0]            WrAddr,
   input  logic [WORD-1:0]           WrData,
   input  logic                      Start,
   input  logic                      SelReady,
`ifdef MEM_BANK_CLEAR_EN
   input  logic                      Clear,
`endif
   output logic [(2**SEL)*WORD-1:0]  DATAflat,
   output logic [SEL-1:0]            Select,
   output logic                      SelValid,
   output logic                      Busy,
   output logic                      Done
);

   localparam logic [SEL-1:0] LAST = '1;

   state_e         state_q, state_d;
   logic [SEL-1:0] sel_q, sel_d;

   mem_bank_regs #(.SEL(SEL), .WORD(WORD)) u_regs (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (WrEn),
      .wr_addr   (WrAddr),
      .wr_data   (WrData),
`ifdef MEM_BANK_CLEAR_EN
      .clear     (Clear),
`endif
      .data_flat (DATAflat)
   );

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      case (state_q)
         IDLE: begin
            if (Start) begin
               state_d = SCAN;
               sel_d   = '0;
            end
         end
         SCAN: begin
            // Start is deliberately not looked at here or in DONE.
            if (SelReady) begin
               if (sel_q == LAST) begin
                  state_d = DONE;
                  sel_d   = '0;
               end else begin
                  sel_d = sel_q + SEL'(1);
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
      end
   end

   assign Select   = sel_q;
   assign SelValid = (state_q == SCAN);
   assign Busy     = (state_q != IDLE);
   assign Done     = (state_q == DONE);

endmodule
